// File: rtl/esm_slot_scheduler.sv
// ---------------------------------------------------------------------------
// esm_slot_scheduler
//
// Slot controller for the ESM dependency core (IRT/IDT). A free buffer slot is
// handed to every dispatched instruction (alloc_index becomes the core's
// buffer_index). The block tracks which slots are occupied and which have been
// issued. It round-robin selects one dependency-clear slot per issue
// handshake, and retires slots on completion reports.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous flush of all slots (highest priority)
//   in_valid     dispatch presents an instruction this cycle
//   in_ready     a free slot exists and no flush is in progress
//   alloc_index  slot given to the current dispatch (lowest free slot)
//   rdy_vec      per-slot "all sources resolved" from the dependency table
//   issue_valid  issue_index holds a selected slot
//   issue_ready  execute unit accepts the issue
//   issue_index  slot being issued
//   cmpl_valid   execute completion report
//   cmpl_index   slot that completed
//   occ_count    number of occupied slots
//   full         every slot is occupied
//   empty        no slot is occupied
//   err          sticky protocol error (bad completion), cleared only by reset
// ---------------------------------------------------------------------------
module esm_slot_scheduler #(
   parameter int bs = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [$clog2(bs)-1:0]     alloc_index,
   input  logic [bs-1:0]             rdy_vec,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [$clog2(bs)-1:0]     issue_index,
   input  logic                      cmpl_valid,
   input  logic [$clog2(bs)-1:0]     cmpl_index,
   output logic [$clog2(bs):0]       occ_count,
   output logic                      full,
   output logic                      empty,
   output logic                      err
);

   localparam int bs_bits = $clog2(bs);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [bs-1:0]      occ_reg,         occ_next;
   logic [bs-1:0]      iss_reg,         iss_next;
   logic [bs_bits-1:0] rr_ptr_reg,      rr_ptr_next;
   logic               issue_valid_reg, issue_valid_next;
   logic [bs_bits-1:0] issue_index_reg, issue_index_next;
   logic               err_reg,         err_next;

   // ------------------------------------------------------------------
   // Occupancy decode
   // ------------------------------------------------------------------
   logic [bs_bits:0]   occ_cnt;
   logic [bs_bits-1:0] alloc_idx;

   always_comb begin
      occ_cnt = '0;
      for (int i = 0; i < bs; i++) begin
         occ_cnt = occ_cnt + (bs_bits + 1)'(occ_reg[i]);
      end
   end

   // The scan runs from the top down, so the last hit is the lowest free slot.
   // When every slot is taken nothing hits and the index stays 0.
   always_comb begin
      alloc_idx = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (!occ_reg[i]) begin
            alloc_idx = bs_bits'(i);
         end
      end
   end

   assign occ_count   = occ_cnt;
   assign full        = (occ_cnt == (bs_bits + 1)'(bs));
   assign empty       = (occ_cnt == '0);
   assign in_ready    = !full && !flush;
   assign alloc_index = alloc_idx;
   assign issue_valid = issue_valid_reg;
   assign issue_index = issue_index_reg;
   assign err         = err_reg;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   logic alloc_fire;
   logic fire;
   logic issue_load;
   logic cmpl_ok;

   assign alloc_fire = in_valid && in_ready;
   assign fire       = issue_valid_reg && issue_ready && !flush;
   assign issue_load = !issue_valid_reg || issue_ready;
   // A slot that is being fired this cycle still has iss=0, so a completion
   // for it in the same cycle is rejected here as a protocol error.
   assign cmpl_ok    = occ_reg[cmpl_index] && iss_reg[cmpl_index];

   // ------------------------------------------------------------------
   // Candidate vector. The slot in the issue register is masked out so that
   // it cannot be selected a second time while it is held or firing.
   // ------------------------------------------------------------------
   logic [bs-1:0] held;
   logic [bs-1:0] cand;

   generate
      for (genvar gi = 0; gi < bs; gi++) begin : g_cand
         assign held[gi] = issue_valid_reg && (issue_index_reg == bs_bits'(gi));
         assign cand[gi] = occ_reg[gi] && !iss_reg[gi] && rdy_vec[gi] && !held[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Round-robin pick: the first candidate at or after the search pointer,
   // wrapping modulo bs (bs is a power of two, so the index simply rolls
   // over). On a fire, the search starts just past the slot that is leaving.
   // That is the pointer value the fire itself installs, which keeps
   // back-to-back issue fair.
   // ------------------------------------------------------------------
   logic [bs_bits-1:0] search_ptr;
   logic [bs_bits-1:0] probe_idx;
   logic [bs_bits-1:0] sel_idx;
   logic               sel_found;

   assign search_ptr = fire ? (issue_index_reg + bs_bits'(1)) : rr_ptr_reg;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = issue_index_reg;
      probe_idx = '0;
      for (int k = 0; k < bs; k++) begin
         probe_idx = search_ptr + bs_bits'(k);
         if (!sel_found && cand[probe_idx]) begin
            sel_found = 1'b1;
            sel_idx   = probe_idx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      occ_next         = occ_reg;
      iss_next         = iss_reg;
      rr_ptr_next      = rr_ptr_reg;
      issue_valid_next = issue_valid_reg;
      issue_index_next = issue_index_reg;
      err_next         = err_reg;

      if (flush) begin
         // Dispatch, fire and completion are all dropped. err survives.
         occ_next         = '0;
         iss_next         = '0;
         rr_ptr_next      = '0;
         issue_valid_next = 1'b0;
      end else begin
         // Completion, allocation and fire always touch distinct slots:
         // completion needs occ=1/iss=1, allocation needs occ=0, and the
         // fired slot has occ=1/iss=0. The updates therefore never collide.
         if (cmpl_valid) begin
            if (cmpl_ok) begin
               occ_next[cmpl_index] = 1'b0;
               iss_next[cmpl_index] = 1'b0;
            end else begin
               err_next = 1'b1;
            end
         end

         if (alloc_fire) begin
            occ_next[alloc_idx] = 1'b1;
            iss_next[alloc_idx] = 1'b0;
         end

         if (fire) begin
            iss_next[issue_index_reg] = 1'b1;
            rr_ptr_next               = issue_index_reg + bs_bits'(1);
         end

         if (issue_load) begin
            issue_valid_next = sel_found;
            if (sel_found) begin
               issue_index_next = sel_idx;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_reg         <= '0;
         iss_reg         <= '0;
         rr_ptr_reg      <= '0;
         issue_valid_reg <= 1'b0;
         issue_index_reg <= '0;
         err_reg         <= 1'b0;
      end else begin
         occ_reg         <= occ_next;
         iss_reg         <= iss_next;
         rr_ptr_reg      <= rr_ptr_next;
         issue_valid_reg <= issue_valid_next;
         issue_index_reg <= issue_index_next;
         err_reg         <= err_next;
      end
   end

endmodule
